// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
//
// Walks the PC and issues one memory request per cycle while fetching is allowed.
// Each accepted request pushes an address entry into the instruction buffer. In-order
// responses push the instruction word in the same cycle they arrive.
// An execute redirect flushes the buffer and restarts fetch at the target. Responses
// already in flight for the old path are counted and dropped before fetch resumes.
//
// Optional feature: define BRANCH_PREDICTOR_EN to add predict_taken_i/predict_address_i.
// On a handshake with predict_taken_i set, fetch follows the predicted target and the
// pushed entry is marked speculative.
//
// Ports:
//   clk_i, rst_n_i               clock, asynchronous active-low reset
//   execute_redirect_i/address_i redirect request and target
//   fetch_request_o/address_o    memory request valid and address (current PC)
//   fetch_accept_i               memory accepts the request this cycle
//   fetch_valid_i/instruction_i  in-order memory response
//   buffer_full_i                instruction buffer cannot take more entries
//   buffer_flush_o               flush instruction buffer
//   buffer_write_*_o             push strobes for address/speculative/instruction entries
//   buffer_address_o/speculative_o/instruction_o  pushed data
module fetch_unit #(
  parameter logic [31:0] RESET_ADDRESS   = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        execute_redirect_i,
  input  logic [31:0] execute_address_i,
  output logic        fetch_request_o,
  output logic [31:0] fetch_address_o,
  input  logic        fetch_accept_i,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_instruction_i,
  input  logic        buffer_full_i,
`ifdef BRANCH_PREDICTOR_EN
  input  logic        predict_taken_i,
  input  logic [31:0] predict_address_i,
`endif
  output logic        buffer_flush_o,
  output logic        buffer_write_address_o,
  output logic        buffer_write_speculative_o,
  output logic        buffer_write_instruction_o,
  output logic [31:0] buffer_address_o,
  output logic        buffer_speculative_o,
  output logic [31:0] buffer_instruction_o
);

  typedef enum logic [1:0] {StBoot, StFetch, StHold, StDrain} state_e;

  localparam logic [3:0] MaxOut = 4'(MAX_OUTSTANDING);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  outstanding_q, outstanding_d;
  logic [3:0]  discard_q, discard_d;

  logic        redirect;
  logic        handshake;
  logic        response;
  logic        predict_taken;
  logic [31:0] predict_target;

`ifdef BRANCH_PREDICTOR_EN
  assign predict_taken  = predict_taken_i;
  assign predict_target = {predict_address_i[31:2], 2'b00};
`else
  assign predict_taken  = 1'b0;
  assign predict_target = pc_q + 32'd4;
`endif

  // Redirects are not honoured during the single boot cycle.
  assign redirect  = execute_redirect_i && (state_q != StBoot);
  assign handshake = fetch_request_o && fetch_accept_i;
  // A response with nothing outstanding is stray and ignored.
  assign response  = fetch_valid_i && (outstanding_q != 4'd0);

  assign fetch_request_o            = (state_q == StFetch) && !execute_redirect_i;
  assign fetch_address_o            = rst_n_i ? pc_q : 32'd0;
  assign buffer_flush_o             = redirect;
  assign buffer_write_address_o     = handshake;
  assign buffer_write_speculative_o = handshake;
  assign buffer_address_o           = handshake ? pc_q : 32'd0;
  assign buffer_speculative_o       = handshake && predict_taken;
  assign buffer_write_instruction_o = response && (discard_q == 4'd0) && !redirect;
  assign buffer_instruction_o       = rst_n_i ? fetch_instruction_i : 32'd0;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    outstanding_d = outstanding_q + {3'b000, handshake} - {3'b000, response};
    discard_d     = discard_q;

    // Stale responses are dropped oldest first; discard only counts old-path requests.
    if (response && (discard_q != 4'd0)) begin
      discard_d = discard_q - 4'd1;
    end

    if (handshake) begin
      pc_d = predict_taken ? predict_target : pc_q + 32'd4;
    end

    case (state_q)
      StBoot:  state_d = StFetch;
      StFetch: begin
        if (buffer_full_i || (outstanding_d == MaxOut)) state_d = StHold;
      end
      StHold: begin
        if (!buffer_full_i && (outstanding_q < MaxOut)) state_d = StFetch;
      end
      StDrain: begin
        if (discard_d == 4'd0) state_d = StFetch;
      end
      default: state_d = StBoot;
    endcase

    // No handshake can coincide with a redirect, so everything still in flight
    // after this cycle's response belongs to the old path.
    if (redirect) begin
      pc_d      = {execute_address_i[31:2], 2'b00};
      discard_d = outstanding_q - {3'b000, response};
      state_d   = (discard_d != 4'd0) ? StDrain : StFetch;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= StBoot;
      pc_q          <= RESET_ADDRESS;
      outstanding_q <= 4'd0;
      discard_q     <= 4'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized traffic, all checked
// against a queue-based model of in-flight requests (each entry marked live or stale).
module tb_fetch_unit;

  localparam logic [31:0] ResetAddr = 32'h0000_0100;
  localparam int unsigned MaxOut    = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        execute_redirect_i;
  logic [31:0] execute_address_i;
  logic        fetch_request_o;
  logic [31:0] fetch_address_o;
  logic        fetch_accept_i;
  logic        fetch_valid_i;
  logic [31:0] fetch_instruction_i;
  logic        buffer_full_i;
  logic        predict_taken_i;
  logic [31:0] predict_address_i;
  logic        buffer_flush_o;
  logic        buffer_write_address_o;
  logic        buffer_write_speculative_o;
  logic        buffer_write_instruction_o;
  logic [31:0] buffer_address_o;
  logic        buffer_speculative_o;
  logic [31:0] buffer_instruction_o;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_ADDRESS  (ResetAddr),
    .MAX_OUTSTANDING(MaxOut)
  ) dut (
    .clk_i                     (clk),
    .rst_n_i                   (rst_n),
    .execute_redirect_i        (execute_redirect_i),
    .execute_address_i         (execute_address_i),
    .fetch_request_o           (fetch_request_o),
    .fetch_address_o           (fetch_address_o),
    .fetch_accept_i            (fetch_accept_i),
    .fetch_valid_i             (fetch_valid_i),
    .fetch_instruction_i       (fetch_instruction_i),
    .buffer_full_i             (buffer_full_i),
`ifdef BRANCH_PREDICTOR_EN
    .predict_taken_i           (predict_taken_i),
    .predict_address_i         (predict_address_i),
`endif
    .buffer_flush_o            (buffer_flush_o),
    .buffer_write_address_o    (buffer_write_address_o),
    .buffer_write_speculative_o(buffer_write_speculative_o),
    .buffer_write_instruction_o(buffer_write_instruction_o),
    .buffer_address_o          (buffer_address_o),
    .buffer_speculative_o      (buffer_speculative_o),
    .buffer_instruction_o      (buffer_instruction_o)
  );

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: PC, boot flag, hold flag and a queue of in-flight requests
  // where 1 marks a request issued before the latest redirect.
  bit          m_booted;
  bit          m_held;
  logic [31:0] m_pc;
  bit          m_q[$];

  // DUT observations from the last step, for scenario-level counting.
  bit          obs_req, obs_hs, obs_flush, obs_wr, obs_spec;
  logic [31:0] obs_faddr, obs_baddr;

  task automatic model_reset();
    m_booted = 1'b0;
    m_held   = 1'b0;
    m_pc     = ResetAddr;
    m_q.delete();
  endtask

  task automatic step(input bit redir, input logic [31:0] raddr, input bit acc, input bit vld,
                      input logic [31:0] ins, input bit full, input bit ptk,
                      input logic [31:0] paddr);
    bit          stale_start, stale_end, req, hs, resp, eff, take, wr_ins;
    int unsigned size_start;
    @(negedge clk);
    execute_redirect_i  = redir;
    execute_address_i   = raddr;
    fetch_accept_i      = acc;
    fetch_valid_i       = vld;
    fetch_instruction_i = ins;
    buffer_full_i       = full;
    predict_taken_i     = ptk;
    predict_address_i   = paddr;
    #1;
    stale_start = 1'b0;
    foreach (m_q[i]) if (m_q[i]) stale_start = 1'b1;
    size_start = m_q.size();
    req  = m_booted && !m_held && !stale_start && !redir;
    hs   = req && acc;
    resp = vld && (size_start > 0);
    eff  = redir && m_booted;
`ifdef BRANCH_PREDICTOR_EN
    take = hs && ptk;
`else
    take = 1'b0;
`endif
    wr_ins = resp && !eff && !m_q[0];

    obs_req   = fetch_request_o;
    obs_hs    = fetch_request_o && fetch_accept_i;
    obs_flush = buffer_flush_o;
    obs_wr    = buffer_write_instruction_o;
    obs_spec  = buffer_speculative_o;
    obs_faddr = fetch_address_o;
    obs_baddr = buffer_address_o;

    check_eq("request", fetch_request_o, req);
    check_eq("fetch_address", fetch_address_o, m_pc);
    check_eq("flush", buffer_flush_o, eff);
    check_eq("write_address", buffer_write_address_o, hs);
    check_eq("write_speculative", buffer_write_speculative_o, hs);
    check_eq("write_instruction", buffer_write_instruction_o, wr_ins);
    check_eq("buffer_instruction", buffer_instruction_o, ins);
    if (hs) begin
      check_eq("buffer_address", buffer_address_o, m_pc);
      check_eq("buffer_speculative", buffer_speculative_o, take);
    end

    if (resp) void'(m_q.pop_front());
    if (hs) begin
      m_q.push_back(1'b0);
      m_pc = take ? {paddr[31:2], 2'b00} : m_pc + 32'd4;
    end
    if (eff) begin
      foreach (m_q[i]) m_q[i] = 1'b1;
      m_pc = {raddr[31:2], 2'b00};
    end
    stale_end = 1'b0;
    foreach (m_q[i]) if (m_q[i]) stale_end = 1'b1;
    if (!m_booted || eff || stale_start || stale_end) m_held = 1'b0;
    else if (m_held) m_held = full || (size_start >= MaxOut);
    else m_held = full || (m_q.size() == MaxOut);
    m_booted = 1'b1;
  endtask

  // Quiet-cycle shorthand: optional accept/valid/full, no redirect or prediction.
  task automatic idle(input bit acc, input bit vld, input bit full);
    step(1'b0, 32'd0, acc, vld, $urandom, full, 1'b0, 32'd0);
  endtask

  // Assert reset mid-cycle with live-looking inputs; outputs must drop at once.
  task automatic async_reset();
    @(negedge clk);
    execute_redirect_i  = 1'b1;
    execute_address_i   = 32'h0000_5554;
    fetch_accept_i      = 1'b1;
    fetch_valid_i       = 1'b1;
    fetch_instruction_i = 32'hDEAD_BEEF;
    buffer_full_i       = 1'b0;
    predict_taken_i     = 1'b1;
    predict_address_i   = 32'h0000_0800;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_request", fetch_request_o, 1'b0);
    check_eq("rst_fetch_address", fetch_address_o, 32'd0);
    check_eq("rst_flush", buffer_flush_o, 1'b0);
    check_eq("rst_write_address", buffer_write_address_o, 1'b0);
    check_eq("rst_write_spec", buffer_write_speculative_o, 1'b0);
    check_eq("rst_write_instr", buffer_write_instruction_o, 1'b0);
    check_eq("rst_buffer_address", buffer_address_o, 32'd0);
    check_eq("rst_buffer_spec", buffer_speculative_o, 1'b0);
    check_eq("rst_buffer_instr", buffer_instruction_o, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  int first_req;
  int unsigned hs_count, wr_count;

  initial begin
    rst_n = 1'b0;
    model_reset();
    async_reset();

    // Boot then sequential fetch; buffer fills during the third handshake.
    first_req = -1;
    hs_count  = 0;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1, 1'b0, i == 3);
      if (obs_req && first_req < 0) first_req = i;
      if (obs_hs) begin
        check_eq("seq_buffer_address", obs_baddr, ResetAddr + 32'(4 * hs_count));
        hs_count++;
      end
    end
    check_eq("first_request_cycle", 32'(first_req), 32'd1);
    check_eq("handshakes_before_full", hs_count, 32'd3);
    idle(1'b1, 1'b0, 1'b1);
    check_eq("full_request_low", obs_req, 1'b0);
    check_eq("full_pc_held", obs_faddr, 32'h0000_010C);
    idle(1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 1'b0);
    check_eq("resume_request", obs_req, 1'b1);
    check_eq("resume_address", obs_faddr, 32'h0000_010C);

    // Four outstanding, no responses: no further handshakes.
    hs_count = 0;
    for (int i = 0; i < 5; i++) begin
      idle(1'b1, 1'b0, 1'b0);
      hs_count += obs_hs;
    end
    check_eq("max_outstanding_stall", hs_count, 32'd0);
    hs_count = 0;
    idle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      idle(1'b1, 1'b0, 1'b0);
      hs_count += obs_hs;
    end
    check_eq("one_response_one_handshake", hs_count, 32'd1);

    // Drop to three outstanding, then redirect to an unaligned target.
    idle(1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_2003, 1'b1, 1'b0, $urandom, 1'b0, 1'b0, 32'd0);
    check_eq("redirect_flush", obs_flush, 1'b1);
    wr_count = 0;
    hs_count = 0;
    for (int i = 0; i < 5; i++) begin
      idle(1'b1, (i % 2) == 0, 1'b0);
      wr_count += obs_wr;
      hs_count += obs_hs;
    end
    check_eq("drain_no_writes", wr_count, 32'd0);
    check_eq("drain_no_requests", hs_count, 32'd0);
    idle(1'b0, 1'b0, 1'b0);
    check_eq("target_request", obs_req, 1'b1);
    check_eq("target_address", obs_faddr, 32'h0000_2000);

    // Two outstanding, redirect coincides with a response.
    idle(1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h0000_3000, 1'b1, 1'b1, $urandom, 1'b0, 1'b0, 32'd0);
    check_eq("coincident_flush", obs_flush, 1'b1);
    check_eq("coincident_dropped", obs_wr, 1'b0);
    idle(1'b1, 1'b1, 1'b0);
    check_eq("second_dropped", obs_wr, 1'b0);
    check_eq("drain_request_low", obs_req, 1'b0);
    idle(1'b0, 1'b0, 1'b0);
    check_eq("after_drain_request", obs_req, 1'b1);
    check_eq("after_drain_address", obs_faddr, 32'h0000_3000);

    // Reset with requests in flight; late responses must be ignored.
    idle(1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 1'b0);
    async_reset();
    wr_count = 0;
    for (int i = 0; i < 3; i++) begin
      idle(1'b0, 1'b1, 1'b0);
      wr_count += obs_wr;
    end
    check_eq("stray_responses_ignored", wr_count, 32'd0);

`ifdef BRANCH_PREDICTOR_EN
    async_reset();
    idle(1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0, $urandom, 1'b0, 1'b1, 32'h0000_0400);
    check_eq("predict_speculative", obs_spec, 1'b1);
    check_eq("predict_from", obs_baddr, 32'h0000_0100);
    idle(1'b0, 1'b0, 1'b0);
    check_eq("predict_next_address", obs_faddr, 32'h0000_0400);
`endif

    // Randomized traffic against the model.
    async_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 16) == 0, $urandom, ($urandom % 4) != 0, $urandom % 2, $urandom,
           ($urandom % 6) == 0, $urandom % 2, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
